// File: rtl/wbu_writeback.sv
// Writeback unit: selects the GPR write source, extends loads,
// counts retired instructions and aborts loads that never answer.
module wbu_writeback #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_rx_valid,
  output logic        wbu_rx_ready,
  input  logic [4:0]  wbu_rx_rd_idx,
  input  logic [2:0]  wbu_rx_sel,
  input  logic [31:0] wbu_rx_data,
  input  logic [2:0]  wbu_rx_ld_funct3,
  input  logic [1:0]  wbu_rx_ld_off,
  input  logic        wbu_mem_rsp_valid,
  output logic        wbu_mem_rsp_ready,
  input  logic [31:0] wbu_mem_rsp_data,
  output logic [4:0]  wbu_tx_rd_idx,
  output logic [31:0] wbu_tx_data,
  output logic [5:0]  wbu_tx_wb_valid,
  output logic [63:0] wbu_tx_instret,
  output logic        wbu_tx_mem_timeout
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic        accept, rsp_hs, tmo_hit, retire;
  logic [5:0]  strobe;
  logic [4:0]  wr_rd;
  logic [31:0] wr_val;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign wbu_rx_ready      = (state == IDLE);
  assign wbu_mem_rsp_ready = (state == WAIT_MEM);
  assign accept = wbu_rx_valid & wbu_rx_ready;
  assign rsp_hs = wbu_mem_rsp_valid & wbu_mem_rsp_ready;
  // A response in the expiry cycle takes priority over the abort.
  assign tmo_hit = (state == WAIT_MEM) & ~wbu_mem_rsp_valid
                 & ((cnt + 16'd1) == 16'(MEM_TIMEOUT));

  always_comb begin
    state_nx = state;
    strobe   = 6'd0;
    retire   = 1'b0;
    wr_rd    = wbu_rx_rd_idx;
    wr_val   = wbu_rx_data;
    case (state)
      IDLE: begin
        if (accept) begin
          case (wbu_rx_sel)
            3'd1:    strobe = 6'b100000;
            3'd2:    strobe = 6'b000001;
            3'd3:    strobe = 6'b000010;
            3'd4:    strobe = 6'b000100;
            3'd5:    strobe = 6'b001000;
            3'd6:    state_nx = WAIT_MEM;
            default: retire = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        wr_rd  = ld_rd;
        wr_val = load_ext(wbu_mem_rsp_data, ld_f3, ld_off);
        if (rsp_hs) begin
          strobe   = 6'b010000;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= 16'd0;
      ld_rd              <= 5'd0;
      ld_f3              <= 3'd0;
      ld_off             <= 2'd0;
      wbu_tx_wb_valid    <= 6'd0;
      wbu_tx_rd_idx      <= 5'd0;
      wbu_tx_data        <= 32'd0;
      wbu_tx_instret     <= 64'd0;
      wbu_tx_mem_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      wbu_tx_wb_valid <= strobe;
      if (|strobe) begin
        wbu_tx_rd_idx <= wr_rd;
        wbu_tx_data   <= (wr_rd == 5'd0) ? 32'd0 : wr_val;
      end
      if ((|strobe) | retire)
        wbu_tx_instret <= wbu_tx_instret + 64'd1;
      if (accept) begin
        ld_rd  <= wbu_rx_rd_idx;
        ld_f3  <= wbu_rx_ld_funct3;
        ld_off <= wbu_rx_ld_off;
      end
      if (state == IDLE)
        cnt <= 16'd0;
      else if (!wbu_mem_rsp_valid)
        cnt <= cnt + 16'd1;
      if (tmo_hit)
        wbu_tx_mem_timeout <= 1'b1;
    end
  end

endmodule
